// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF measurement engine.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COUNT,
        COMPARE,
        DONE
    } state_t;

    localparam int unsigned SETTLE_CYC = 3;

    // Oscillator index for base + offset, wrapping inside a power-of-two bank.
    function automatic int unsigned pair_index(input int unsigned base,
                                               input int unsigned offset,
                                               input int unsigned num_ro);
        return (base + offset) & (num_ro - 1);
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Selects one oscillator, synchronises it into clk and counts its rising edges
// with a saturating counter.
module ro_edge_counter #(
    parameter int unsigned NUM_RO = 16,
    parameter int unsigned SEL_W  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_RO-1:0] ro_in,
    input  logic [SEL_W-1:0]  sel,
    input  logic              clr,
    input  logic              en,
    output logic [CNT_W-1:0]  cnt
);

    logic sync_1;
    logic sync_2;
    logic prev;
    logic rise_c;

    assign rise_c = sync_2 & ~prev;

    // Two-flop synchroniser, edge-detect flop and saturating counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            prev   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= ro_in[sel];
            sync_2 <= sync_1;
            prev   <= sync_2;
            if (clr) begin
                cnt <= '0;
            end else if (en && rise_c && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ro_puf_engine.sv
// Ring-oscillator PUF measurement controller: runs RESP_BITS pairwise frequency
// comparisons per challenge and reports a response word plus a tie mask.
module ro_puf_engine
    import ro_puf_pkg::*;
#(
    parameter int unsigned NUM_RO    = 16,
    parameter int unsigned SEL_W     = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned WIN_W     = 12,
    parameter int unsigned RESP_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 start,
    input  logic [SEL_W-1:0]     challenge,
    input  logic [WIN_W-1:0]     win_len,
    input  logic [NUM_RO-1:0]    ro_in,
    output logic [NUM_RO-1:0]    ro_en,
    output logic                 busy,
    output logic [RESP_BITS-1:0] resp,
    output logic [RESP_BITS-1:0] tie_mask,
    output logic                 resp_valid
);

    localparam int unsigned K_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int unsigned SET_W = 2;

    state_t               state, state_d;
    logic [SEL_W-1:0]     base, base_d;
    logic [WIN_W-1:0]     win, win_d;
    logic [WIN_W-1:0]     win_cnt, win_cnt_d;
    logic [K_W-1:0]       k, k_d;
    logic [SET_W-1:0]     set_cnt, set_cnt_d;
    logic [RESP_BITS-1:0] resp_sh, resp_sh_d;
    logic [RESP_BITS-1:0] tie_sh, tie_sh_d;
    logic [RESP_BITS-1:0] resp_d, tie_mask_d;
    logic [NUM_RO-1:0]    ro_en_d;
    logic                 busy_d;
    logic                 resp_valid_d;

    logic [SEL_W-1:0]     sel_a_c, sel_b_c;
    logic                 cnt_clr_c, cnt_en_c;
    logic [CNT_W-1:0]     cnt_a, cnt_b;

    function automatic logic [SEL_W-1:0] osc_a(input logic [SEL_W-1:0] b,
                                               input logic [K_W-1:0]   kk);
        return SEL_W'(pair_index(32'(b), 32'(kk) << 1, NUM_RO));
    endfunction

    function automatic logic [SEL_W-1:0] osc_b(input logic [SEL_W-1:0] b,
                                               input logic [K_W-1:0]   kk);
        return SEL_W'(pair_index(32'(b), (32'(kk) << 1) + 32'd1, NUM_RO));
    endfunction

    function automatic logic [NUM_RO-1:0] pair_mask(input logic [SEL_W-1:0] b,
                                                    input logic [K_W-1:0]   kk);
        return (NUM_RO'(1) << osc_a(b, kk)) | (NUM_RO'(1) << osc_b(b, kk));
    endfunction

    assign sel_a_c   = osc_a(base, k);
    assign sel_b_c   = osc_b(base, k);
    assign cnt_clr_c = (state == SETTLE);
    assign cnt_en_c  = (state == COUNT);

    ro_edge_counter #(.NUM_RO(NUM_RO), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ro_in (ro_in),
        .sel   (sel_a_c),
        .clr   (cnt_clr_c),
        .en    (cnt_en_c),
        .cnt   (cnt_a)
    );

    ro_edge_counter #(.NUM_RO(NUM_RO), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ro_in (ro_in),
        .sel   (sel_b_c),
        .clr   (cnt_clr_c),
        .en    (cnt_en_c),
        .cnt   (cnt_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base       <= '0;
            win        <= '0;
            win_cnt    <= '0;
            k          <= '0;
            set_cnt    <= '0;
            resp_sh    <= '0;
            tie_sh     <= '0;
            ro_en      <= '0;
            busy       <= 1'b0;
            resp       <= '0;
            tie_mask   <= '0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_d;
            base       <= base_d;
            win        <= win_d;
            win_cnt    <= win_cnt_d;
            k          <= k_d;
            set_cnt    <= set_cnt_d;
            resp_sh    <= resp_sh_d;
            tie_sh     <= tie_sh_d;
            ro_en      <= ro_en_d;
            busy       <= busy_d;
            resp       <= resp_d;
            tie_mask   <= tie_mask_d;
            resp_valid <= resp_valid_d;
        end
    end

    // Enables are loaded on entry to SETTLE so they are already valid while it runs.
    always_comb begin
        state_d      = state;
        base_d       = base;
        win_d        = win;
        win_cnt_d    = win_cnt;
        k_d          = k;
        set_cnt_d    = set_cnt;
        resp_sh_d    = resp_sh;
        tie_sh_d     = tie_sh;
        ro_en_d      = ro_en;
        busy_d       = busy;
        resp_d       = resp;
        tie_mask_d   = tie_mask;
        resp_valid_d = 1'b0;

        case (state)
            IDLE: begin
                if (start && ena) begin
                    state_d   = SETTLE;
                    base_d    = challenge;
                    win_d     = (win_len == '0) ? WIN_W'(1) : win_len;
                    k_d       = '0;
                    set_cnt_d = '0;
                    busy_d    = 1'b1;
                    ro_en_d   = pair_mask(challenge, '0);
                end
            end
            SETTLE: begin
                if (set_cnt == SET_W'(SETTLE_CYC - 1)) begin
                    state_d   = COUNT;
                    win_cnt_d = '0;
                end else begin
                    set_cnt_d = set_cnt + SET_W'(1);
                end
            end
            COUNT: begin
                if (win_cnt == win - WIN_W'(1)) begin
                    state_d = COMPARE;
                    ro_en_d = '0;
                end else begin
                    win_cnt_d = win_cnt + WIN_W'(1);
                end
            end
            COMPARE: begin
                resp_sh_d[k] = (cnt_a > cnt_b);
                tie_sh_d[k]  = (cnt_a == cnt_b);
                if (k == K_W'(RESP_BITS - 1)) begin
                    state_d      = DONE;
                    resp_d       = resp_sh_d;
                    tie_mask_d   = tie_sh_d;
                    resp_valid_d = 1'b1;
                    busy_d       = 1'b0;
                end else begin
                    state_d   = SETTLE;
                    k_d       = k + K_W'(1);
                    set_cnt_d = '0;
                    ro_en_d   = pair_mask(base, k + K_W'(1));
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Dropping ena abandons the run without touching the published result.
        if ((state != IDLE) && !ena) begin
            state_d      = IDLE;
            ro_en_d      = '0;
            busy_d       = 1'b0;
            resp_valid_d = 1'b0;
            resp_d       = resp;
            tie_mask_d   = tie_mask;
        end
    end

endmodule

// File: doc/ro_puf_engine.md
Name: ro_puf_engine

Overview:
- Parametrised ring-oscillator PUF measurement engine: sequences RESP_BITS pairwise frequency comparisons over an external bank of NUM_RO free-running ring oscillators.
- Produces a RESP_BITS-wide response word per challenge.
- Oscillators stay outside this block; it drives their enables and counts their edges.
- Replaces the fixed mux + async counter + comparator chain with a fully synchronous, single-clock measurement controller with a start/valid handshake, programmable gate window and tie detection.

Parameters:
- NUM_RO, 16, number of oscillators (power of two, >= 4)
- SEL_W, 4, log2(NUM_RO)
- CNT_W, 16, edge-counter width
- WIN_W, 12, gate-window length width
- RESP_BITS, 8, response bits per challenge

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; low aborts any run
- start  in  1  single-cycle request; sampled in IDLE only
- challenge  in  SEL_W  base oscillator index, captured on accepted start
- win_len  in  WIN_W  gate window in clk cycles, captured on accepted start; 0 treated as 1
- ro_in  in  NUM_RO  raw oscillator outputs, asynchronous to clk
- ro_en  out  NUM_RO  oscillator enables
- busy  out  1  high from accepted start until IDLE re-entered
- resp  out  RESP_BITS  response word
- tie_mask  out  RESP_BITS  bit k set when pair k counts were equal
- resp_valid  out  1  one-cycle pulse when resp/tie_mask update

Behaviour:
- Reset: state IDLE; ro_en, busy, resp, tie_mask, resp_valid, counters and bit index all 0.
- Start acceptance: start is accepted when state is IDLE, start=1 and ena=1.
  - Capture challenge to c, win_len to W (0 becomes 1), k=0.
  - busy goes high the next cycle.
  - start while busy is ignored.
- Pair k (0..RESP_BITS-1):
  - A = (c + 2k) mod NUM_RO
  - B = (c + 2k + 1) mod NUM_RO
  - Index arithmetic wraps at SEL_W bits.
- SETTLE: SETTLE_CYC = 3 cycles.
  - ro_en[A] and ro_en[B] are high; all other ro_en bits are 0.
  - Both counters cleared.
  - No counting, so the 2-flop synchronisers fill.
- COUNT: exactly W cycles.
  - ro_en unchanged.
  - Each counter increments on every synchronised rising edge of its selected ro_in.
  - Counters saturate at all-ones and never wrap.
  - Oscillators must toggle slower than clk/2; faster edges may be missed. This is specified, not an error.
- COMPARE: 1 cycle.
  - ro_en = 0.
  - Internal resp_sh[k] = (cnt_a > cnt_b).
  - tie_sh[k] = (cnt_a == cnt_b); a tie gives response bit 0.
  - If k = RESP_BITS-1, go to DONE; else k++ and go to SETTLE.
- DONE: 1 cycle.
  - resp <= resp_sh and tie_mask <= tie_sh.
  - resp_valid = 1 and busy = 0 in this cycle.
  - Next state is IDLE.
- Latency: accepted start to resp_valid = 1 + RESP_BITS*(SETTLE_CYC + W + 1) cycles.
- resp and tie_mask hold until the next DONE; they are not cleared by a new start.
- ena low in any non-IDLE state:
  - Next cycle: IDLE, ro_en = 0, busy = 0.
  - No resp_valid; resp and tie_mask keep their previous values.
- rst_n asserted mid-run: immediate return to the reset values.
- Only the two selected oscillators are ever enabled, and never outside SETTLE/COUNT.

Decomposition:
- Package ro_puf_pkg holds:
  - state enum {IDLE, SETTLE, COUNT, COMPARE, DONE}
  - SETTLE_CYC = 3
  - helper function for the pair-index wrap
- Sub-module ro_edge_counter, instantiated twice (A and B):
  - input mux from ro_in by index
  - 2-flop synchroniser plus edge-detect flop
  - clear/enable saturating CNT_W counter

Test Plan:
- Basic ordering: NUM_RO=16, W=100, c=0. Bench drives ro_in[i] with toggle half-period 2+i cycles (lower index is faster) → resp=8'hFF, tie_mask=0, resp_valid exactly 1+8*104=833 cycles after start.
- Index wrap: c=13. Pair 1 is (15,0); pair 2 is (1,2). Check the ro_en one-hot pairs each SETTLE. Same stimulus → resp=8'hFD, since pair 1 compares 15 vs 0 (slower A).
- Ties and saturation:
  - All ro_in tied to 0 → resp=0, tie_mask=8'hFF.
  - CNT_W=4, W=200, fast toggles on A (half-period 2), slower toggles on B (half-period 4): both counters saturate at 15 → tie_mask bit set.
- win_len=0: runs as W=1. resp_valid 1+8*5=41 cycles after start.
- Abort:
  - ena dropped in pair 3 COUNT → next cycle busy=0, ro_en=0, no resp_valid, previous resp held.
  - start pulsed while busy → ignored.
- Reset mid-run: rst_n low during COMPARE → all outputs 0 asynchronously. A new start after release completes normally.
